// File: rtl/subtractor_serial4.sv
// rtl/subtractor_serial4.sv - bit-serial a - b, LSB first, one borrow FF; optional SUB_OVF_EN adds signed overflow flag
module subtractor_serial4 #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] q,
   output logic             borrow,
   output logic             busy,
   output logic             done
`ifdef SUB_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_next;

   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_q;
   logic [CW-1:0]    r_cnt;
   logic             r_bf;
   logic             r_borrow;

   logic             w_accept;
   logic             w_last;
   logic             w_d;
   logic             w_bf_next;

`ifdef SUB_OVF_EN
   logic             r_a_msb;
   logic             r_b_msb;
   logic             r_ovf;
`endif

   // one full-subtractor bit slice fed by the low bits of the operand shifters
   assign w_d       = r_a[0] ^ r_b[0] ^ r_bf;
   assign w_bf_next = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_bf);
   assign w_accept  = (r_state == S_IDLE) && start;
   assign w_last    = (r_state == S_RUN) && (r_cnt == LAST);

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // next-state decode: start only honoured in IDLE, so restarts while busy are dropped
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  w_next = start ? S_RUN : S_IDLE;
         S_RUN:   w_next = (r_cnt == LAST) ? S_DONE : S_RUN;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // status outputs decoded from state; done is high only for the single DONE cycle
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (r_state)
         S_RUN:   busy = 1'b1;
         S_DONE:  begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: begin
            busy = 1'b0;
            done = 1'b0;
         end
      endcase
   end

   // datapath: latch operands on accept, then shift one difference bit per RUN cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a      <= '0;
         r_b      <= '0;
         r_q      <= '0;
         r_cnt    <= '0;
         r_bf     <= 1'b0;
         r_borrow <= 1'b0;
`ifdef SUB_OVF_EN
         r_a_msb  <= 1'b0;
         r_b_msb  <= 1'b0;
         r_ovf    <= 1'b0;
`endif
      end else if (w_accept) begin
         r_a      <= a;
         r_b      <= b;
         r_bf     <= 1'b0;
         r_cnt    <= '0;
`ifdef SUB_OVF_EN
         r_a_msb  <= a[WIDTH-1];
         r_b_msb  <= b[WIDTH-1];
`endif
      end else if (r_state == S_RUN) begin
         r_q   <= {w_d, r_q[WIDTH-1:1]};
         r_a   <= r_a >> 1;
         r_b   <= r_b >> 1;
         r_bf  <= w_bf_next;
         r_cnt <= r_cnt + CW'(1);
         if (w_last) begin
            // the last slice produces the result MSB, so flags settle together with q
            r_borrow <= w_bf_next;
`ifdef SUB_OVF_EN
            r_ovf    <= (r_a_msb ^ r_b_msb) & (w_d ^ r_a_msb);
`endif
         end
      end
   end

   assign q      = r_q;
   assign borrow = r_borrow;
`ifdef SUB_OVF_EN
   assign ovf    = r_ovf;
`endif

endmodule

// File: tb/tb_subtractor_serial4.sv
// tb/tb_subtractor_serial4.sv - directed bench for subtractor_serial4
module tb_subtractor_serial4;

   logic       clk;
   logic       rst;
   logic       start;
   logic [3:0] a;
   logic [3:0] b;
   logic [3:0] q;
   logic       borrow;
   logic       busy;
   logic       done;
`ifdef SUB_OVF_EN
   logic       ovf;
`endif

   int n_assert;
   int n_fail;

   subtractor_serial4 #(.WIDTH(4)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .a      (a),
      .b      (b),
      .q      (q),
      .borrow (borrow),
      .busy   (busy),
      .done   (done)
`ifdef SUB_OVF_EN
      ,
      .ovf    (ovf)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // start pulse at edge 0, scramble inputs afterwards, check done timing and result
   task automatic run_op(input string tag, input logic [3:0] ia, input logic [3:0] ib,
                         input logic [3:0] eq, input logic eb, input logic eo);
      @(negedge clk);
      a = ia;
      b = ib;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      a = ~ia;
      b = ~ib;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk({tag, "_busy_run"}, 32'(busy), 32'd1);
         chk({tag, "_nodone_early"}, 32'(done), 32'd0);
         @(posedge clk);
      end
      @(negedge clk);
      chk({tag, "_done"}, 32'(done), 32'd1);
      chk({tag, "_q"}, 32'(q), 32'(eq));
      chk({tag, "_borrow"}, 32'(borrow), 32'(eb));
`ifdef SUB_OVF_EN
      chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
`else
      if (eo === 1'bx) chk({tag, "_ovf_arg"}, 32'(eo), 32'd0);
`endif
      @(posedge clk);
      @(negedge clk);
      chk({tag, "_done_fall"}, 32'(done), 32'd0);
      chk({tag, "_busy_fall"}, 32'(busy), 32'd0);
      chk({tag, "_q_hold"}, 32'(q), 32'(eq));
   endtask

   int first_done;
   int last_done;
   int n_done;
   int q_bad;
   int saw_done;

   initial begin
      n_assert = 0;
      n_fail   = 0;
      rst   = 1'b1;
      start = 1'b0;
      a     = 4'd0;
      b     = 4'd0;
      #2;
      chk("reset_q", 32'(q), 32'd0);
      chk("reset_borrow", 32'(borrow), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      run_op("basic_3m2", 4'd3, 4'd2, 4'd1, 1'b0, 1'b0);
      run_op("under_2m3", 4'd2, 4'd3, 4'hf, 1'b1, 1'b0);
      run_op("under_0m1", 4'd0, 4'd1, 4'hf, 1'b1, 1'b0);
      run_op("equal_fmf", 4'hf, 4'hf, 4'h0, 1'b0, 1'b0);
      run_op("equal_0m0", 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
      run_op("ovf_8m1", 4'h8, 4'h1, 4'h7, 1'b0, 1'b1);
      run_op("ovf_7mf", 4'h7, 4'hf, 4'h8, 1'b1, 1'b1);

      // restart request mid-RUN must be ignored
      @(negedge clk);
      a = 4'd3;
      b = 4'd2;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      #1;
      a = 4'd1;
      b = 4'd1;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      chk("repulse_nodone_e2", 32'(done), 32'd0);
      @(negedge clk);
      chk("repulse_nodone_e3", 32'(done), 32'd0);
      @(negedge clk);
      chk("repulse_done", 32'(done), 32'd1);
      chk("repulse_q", 32'(q), 32'd1);
      @(negedge clk);
      chk("repulse_done_single", 32'(done), 32'd0);
      chk("repulse_idle", 32'(busy), 32'd0);

      // start held high: done every WIDTH+2 cycles
      a = 4'd5;
      b = 4'd3;
      start = 1'b1;
      n_done = 0;
      first_done = -1;
      last_done = -1;
      q_bad = 0;
      for (int c = 0; c <= 16; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (done === 1'b1) begin
            n_done++;
            if (first_done < 0) first_done = c;
            last_done = c;
            if (q !== 4'd2) q_bad++;
         end
      end
      start = 1'b0;
      chk("held_done_count", 32'(n_done), 32'd3);
      chk("held_first_done", 32'(first_done), 32'd4);
      chk("held_last_done", 32'(last_done), 32'd16);
      chk("held_q_bad", 32'(q_bad), 32'd0);
      @(negedge clk);
      chk("held_idle_after", 32'(busy), 32'd0);

      // reset during RUN aborts the operation without a done
      @(negedge clk);
      a = 4'd9;
      b = 4'd2;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("abort_q", 32'(q), 32'd0);
      chk("abort_borrow", 32'(borrow), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
`ifdef SUB_OVF_EN
      chk("abort_ovf", 32'(ovf), 32'd0);
`endif
      @(negedge clk);
      rst = 1'b0;
      saw_done = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) saw_done++;
      end
      chk("abort_no_done", 32'(saw_done), 32'd0);

      run_op("recover_3m2", 4'd3, 4'd2, 4'd1, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

endmodule
